imu_array_reader: RTL and testbench
===================================

IMU_ARRAY_READER -- requirements
Module: imu_array_reader

Interface
REQ-001 Parameters, one per line:
- CLK_DIV, default 4: clk cycles per SCLK half-period; legal range 1..255.
- FRAME_BITS, default 128: SCLK cycles per IMU frame; legal range 16..256.
- CS_SETUP, default 4: clk cycles from CS_N falling to the first SCLK falling edge; minimum 1.
- CS_HOLD, default 4: clk cycles from the last SCLK rising edge to CS_N rising; minimum 1.

REQ-002 Ports, one per line (name, direction, width, meaning):
- clk, in, 1: system clock; one clock domain only.
- rst, in, 1: asynchronous, active-high reset.
- start, in, 1: single-cycle frame request.
- cmd_word, in, 16: burst command, latched on the accepted start.
- imu_miso, in, 32: MISO lines of IMU1..IMU32; bit n-1 is IMUn.
- imu_sclk, out, 1: shared SCLK to all IMUs; SPI mode 3.
- imu_cs_n, out, 1: shared active-low chip select.
- imu_mosi, out, 1: shared MOSI.
- bit_valid, out, 1: one-cycle strobe per sampled bit.
- bit_data, out, 32: MISO sample taken at the current SCLK rising edge.
- bit_index, out, 8: index of the sampled bit, 0..FRAME_BITS-1.
- frame_done, out, 1: one-cycle pulse at frame end.
- busy, out, 1: high from the accepted start until frame_done.

Function
REQ-003 The block SHALL implement four states: IDLE, SETUP, XFER, HOLD.
REQ-004 IDLE: start=1 at a clk edge SHALL latch cmd_word, set imu_cs_n=0 and busy=1 after that edge, and enter SETUP.
REQ-005 start while busy=1 SHALL be ignored, with no queuing.
REQ-006 SETUP SHALL last exactly CS_SETUP cycles with imu_sclk=1 and imu_mosi=cmd_word[15], then enter XFER.
REQ-007 XFER SHALL generate FRAME_BITS SCLK periods of 2*CLK_DIV clk cycles each.
- Each period: imu_sclk=0 for CLK_DIV cycles, then imu_sclk=1 for CLK_DIV cycles.
REQ-008 imu_mosi SHALL change only on SCLK falling edges.
- Bit k drives cmd_word[15-k] for k<16, else 0, MSB first.
REQ-009 On each SCLK rising edge the block SHALL register imu_miso into bit_data.
- bit_valid=1 and bit_index=k SHALL follow for exactly one clk cycle, with 1-cycle latency after the rising edge.
REQ-010 bit_data and bit_index SHALL hold their values between strobes.
REQ-011 After the last rising edge plus CLK_DIV cycles, the block SHALL enter HOLD.
- HOLD lasts CS_HOLD cycles with imu_sclk=1 and imu_cs_n=0.
- It then sets imu_cs_n=1, pulses frame_done for 1 cycle, clears busy in that same cycle, and returns to IDLE.
REQ-012 start SHALL be accepted in the cycle immediately after frame_done.
REQ-013 Total frame length SHALL be CS_SETUP + 2*CLK_DIV*FRAME_BITS + CS_HOLD cycles from imu_cs_n falling to imu_cs_n rising.
REQ-014 The bit counter SHALL saturate at FRAME_BITS-1 and SHALL NOT wrap within a frame.
REQ-015 The divider counter SHALL reset to 0 on every state entry.

Reset
REQ-016 rst=1 SHALL asynchronously force the following, regardless of state, including mid-frame:
- state=IDLE, imu_sclk=1, imu_cs_n=1, imu_mosi=0.
- bit_valid=0, bit_data=0, bit_index=0.
- frame_done=0, busy=0, all counters 0.
REQ-017 A frame aborted by reset SHALL NOT produce frame_done.
REQ-018 start asserted in the first cycle after rst release SHALL be accepted.

Structure
REQ-019 State encoding and the IMU count (32) SHALL live in a shared package, imu_array_pkg.
- The package also carries the default burst command constant 16'h6800, shared with the host-side SPI slave.
REQ-020 One sub-module is natural: imu_sclk_gen (divider plus rise/fall strobes).
- All other logic stays flat in imu_array_reader.

Verification (CLK_DIV=2, FRAME_BITS=128, CS_SETUP=4, CS_HOLD=4 unless stated)
REQ-021 start with cmd_word=16'h6800 -> the following SHALL hold:
- 128 SCLK pulses.
- MOSI bits 0..15 = 0110100000000000, bits 16..127 = 0.
- imu_cs_n low for exactly 4+512+4=520 cycles.
- One frame_done.
REQ-022 imu_miso driven with the pattern per IMU n = bit k XOR (n odd) -> 128 bit_valid strobes, bit_index 0..127 in order, and bit_data matching the applied pattern.
REQ-023 start re-pulsed during SETUP, XFER and HOLD -> no effect; start in the cycle after frame_done -> the second frame begins with imu_cs_n low in the next cycle.
REQ-024 rst asserted at bit 60 of XFER -> the same cycle shows imu_cs_n=1, imu_sclk=1, busy=0, and no frame_done ever appears; a new start then yields a full 128-bit frame.
REQ-025 CLK_DIV=1, FRAME_BITS=16 -> SCLK period 2 cycles, 16 strobes, imu_cs_n low for 4+32+4=40 cycles.

Source files
------------

// File: rtl/imu_array_pkg.sv
// imu_array_pkg: FSM encoding and array constants shared by the IMU burst reader and the host-side SPI slave
package imu_array_pkg;
  localparam int IMU_COUNT = 32;
  localparam logic [15:0] DEFAULT_BURST_CMD = 16'h6800;
  typedef enum logic [1:0] {IDLE, SETUP, XFER, HOLD} state_t;
endpackage

// File: rtl/imu_sclk_gen.sv
// imu_sclk_gen: half-period divider that flags the clk edges where SCLK must rise or fall
module imu_sclk_gen #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic sclk,
  output logic rise,
  output logic fall
);
  logic [7:0] div;
  logic tick;
  assign tick = en && div == 8'(CLK_DIV - 1);
  assign rise = tick && !sclk;
  assign fall = tick && sclk;
  // held at zero outside the transfer so every entry starts a fresh half-period
  always_ff @(posedge clk or posedge rst)
    if (rst) div <= '0;
    else div <= (!en || tick) ? '0 : div + 8'd1;
endmodule

// File: rtl/imu_array_reader.sv
// imu_array_reader: clocks one SPI mode-3 burst frame to a 32-IMU array and streams each MISO bit-slice
module imu_array_reader
  import imu_array_pkg::*;
#(
  parameter int CLK_DIV = 4,
  parameter int FRAME_BITS = 128,
  parameter int CS_SETUP = 4,
  parameter int CS_HOLD = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [15:0]          cmd_word,
  input  logic [IMU_COUNT-1:0] imu_miso,
  output logic                 imu_sclk,
  output logic                 imu_cs_n,
  output logic                 imu_mosi,
  output logic                 bit_valid,
  output logic [IMU_COUNT-1:0] bit_data,
  output logic [7:0]           bit_index,
  output logic                 frame_done,
  output logic                 busy
);
  localparam logic [7:0] LAST_BIT = 8'(FRAME_BITS - 1);
  localparam logic [15:0] SETUP_LAST = 16'(CS_SETUP - 1);
  localparam logic [15:0] HOLD_LAST = 16'(CS_HOLD - 1);
  state_t state;
  logic [14:0] cmd_sr;
  logic [15:0] cnt;
  logic [7:0] bit_cnt;
  logic rise, fall, rise_q;
  imu_sclk_gen #(.CLK_DIV(CLK_DIV)) u_sclk_gen (
    .clk(clk),
    .rst(rst),
    .en(state == XFER),
    .sclk(imu_sclk),
    .rise(rise),
    .fall(fall)
  );
  // MISO is sampled one clk after SCLK goes high, once the line has settled at every IMU
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      imu_sclk <= 1'b1;
      imu_cs_n <= 1'b1;
      imu_mosi <= 1'b0;
      bit_valid <= 1'b0;
      bit_data <= '0;
      bit_index <= '0;
      frame_done <= 1'b0;
      busy <= 1'b0;
      cmd_sr <= '0;
      cnt <= '0;
      bit_cnt <= '0;
      rise_q <= 1'b0;
    end else begin
      bit_valid <= rise_q;
      frame_done <= 1'b0;
      rise_q <= rise;
      if (rise_q) begin
        bit_data <= imu_miso;
        bit_index <= bit_cnt;
      end
      case (state)
        IDLE:
          if (start) begin
            state <= SETUP;
            cmd_sr <= cmd_word[14:0];
            imu_mosi <= cmd_word[15];
            imu_cs_n <= 1'b0;
            busy <= 1'b1;
            cnt <= '0;
            bit_cnt <= '0;
          end
        SETUP:
          if (cnt == SETUP_LAST) begin
            state <= XFER;
            imu_sclk <= 1'b0;
            cnt <= '0;
          end else cnt <= cnt + 16'd1;
        XFER:
          if (rise) imu_sclk <= 1'b1;
          else if (fall && bit_cnt == LAST_BIT) begin
            state <= HOLD;
            cnt <= '0;
          end else if (fall) begin
            imu_sclk <= 1'b0;
            imu_mosi <= cmd_sr[14];
            cmd_sr <= {cmd_sr[13:0], 1'b0};
            bit_cnt <= bit_cnt + 8'd1;
          end
        HOLD:
          if (cnt == HOLD_LAST) begin
            state <= IDLE;
            imu_cs_n <= 1'b1;
            imu_mosi <= 1'b0;
            frame_done <= 1'b1;
            busy <= 1'b0;
            cnt <= '0;
          end else cnt <= cnt + 16'd1;
      endcase
    end
endmodule

// File: tb/tb_imu_array_reader.sv
// tb_imu_array_reader: frame-level checks of two reader configurations against a bit-slice model
module tb_imu_array_reader;
  logic clk = 1'b0, rst = 1'b1, start_a = 1'b0, start_b = 1'b0, sel = 1'b0;
  logic [15:0] cmd_word = '0;
  logic [31:0] imu_miso = '0;
  logic sclk_a, cs_n_a, mosi_a, valid_a, done_a, busy_a;
  logic sclk_b, cs_n_b, mosi_b, valid_b, done_b, busy_b;
  logic [31:0] data_a, data_b;
  logic [7:0] idx_a, idx_b;
  logic s_sclk, s_cs_n, s_mosi, s_valid, s_done, s_busy;
  logic [31:0] s_data;
  logic [7:0] s_idx;
  int n_checks = 0, n_pass = 0;

  typedef struct {
    logic [15:0] cmd;
    int mode;
    logic [15:0] exp_mosi;
    bit sel;
    bit poke;
    int exp_len;
    int exp_bits;
  } vec_t;
  vec_t vecs [6];

  always #5 clk = ~clk;

  imu_array_reader #(.CLK_DIV(2), .FRAME_BITS(128), .CS_SETUP(4), .CS_HOLD(4)) dut_a (
    .clk(clk), .rst(rst), .start(start_a), .cmd_word(cmd_word), .imu_miso(imu_miso),
    .imu_sclk(sclk_a), .imu_cs_n(cs_n_a), .imu_mosi(mosi_a), .bit_valid(valid_a),
    .bit_data(data_a), .bit_index(idx_a), .frame_done(done_a), .busy(busy_a)
  );
  imu_array_reader #(.CLK_DIV(1), .FRAME_BITS(16), .CS_SETUP(4), .CS_HOLD(4)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .cmd_word(cmd_word), .imu_miso(imu_miso),
    .imu_sclk(sclk_b), .imu_cs_n(cs_n_b), .imu_mosi(mosi_b), .bit_valid(valid_b),
    .bit_data(data_b), .bit_index(idx_b), .frame_done(done_b), .busy(busy_b)
  );

  assign s_sclk = sel ? sclk_b : sclk_a;
  assign s_cs_n = sel ? cs_n_b : cs_n_a;
  assign s_mosi = sel ? mosi_b : mosi_a;
  assign s_valid = sel ? valid_b : valid_a;
  assign s_done = sel ? done_b : done_a;
  assign s_busy = sel ? busy_b : busy_a;
  assign s_data = sel ? data_b : data_a;
  assign s_idx = sel ? idx_b : idx_a;

  task automatic check(input string name, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, got, exp);
  endtask

  // IMU n drives bit k as (k odd) xor (n odd); IMU n sits on bit n-1
  function automatic logic [31:0] xor_pat(input int k);
    logic [31:0] w;
    for (int n = 1; n <= 32; n++) w[n-1] = k[0] ^ n[0];
    return w;
  endfunction

  task automatic do_frame(input vec_t v, input bit no_wait);
    logic [31:0] pat [256];
    logic [15:0] mosi_got = '0;
    logic [31:0] hold_data;
    logic [7:0] hold_idx;
    logic prev_sclk = 1'b1;
    int low = 0, rises = 0, falls = 0, strobes = 0, tail = 0, fdone = 0, cyc = 0, last_rise = 0;
    int bad_idx = 0, bad_data = 0, bad_hold = 0, bad_period = 0, idle_low = 0;
    int div = v.sel ? 1 : 2;
    bit done = 1'b0;
    sel = v.sel;
    for (int k = 0; k < 256; k++) pat[k] = (v.mode == 0) ? xor_pat(k) : $urandom;
    if (!no_wait) @(negedge clk);
    cmd_word = v.cmd;
    if (v.sel) start_b = 1'b1; else start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    start_b = 1'b0;
    check("accept", int'({s_cs_n, s_busy, s_sclk, s_mosi}), int'({1'b0, 1'b1, 1'b1, v.cmd[15]}));
    hold_data = s_data;
    hold_idx = s_idx;
    while (!done && cyc < 2000) begin
      cyc++;
      if (!s_cs_n) low++;
      if (prev_sclk && !s_sclk) begin
        imu_miso = pat[falls % 256];
        falls++;
      end
      if (!prev_sclk && s_sclk) begin
        if (rises > 0 && cyc - last_rise != 2 * div) bad_period++;
        last_rise = cyc;
        if (rises < 16) mosi_got[15-rises] = s_mosi;
        else tail += int'(s_mosi);
        rises++;
      end
      if (s_valid) begin
        if (int'(s_idx) != strobes) bad_idx++;
        if (s_data != pat[strobes % 256]) bad_data++;
        strobes++;
      end else if (s_data != hold_data || s_idx != hold_idx) bad_hold++;
      hold_data = s_data;
      hold_idx = s_idx;
      if (s_done) begin
        fdone++;
        check("done_cycle", int'({s_cs_n, s_busy}), 2);
        done = 1'b1;
      end
      if (v.poke) begin
        start_a = (cyc == 2 || cyc == 100 || cyc == v.exp_len - 2);
        if (start_a) cmd_word = ~v.cmd;
      end
      prev_sclk = s_sclk;
      if (!done) @(negedge clk);
    end
    start_a = 1'b0;
    check("frame_end", int'(done), 1);
    check("cs_low_len", low, v.exp_len);
    check("sclk_rises", rises, v.exp_bits);
    check("strobes", strobes, v.exp_bits);
    check("mosi_bits", int'(mosi_got), int'(v.exp_mosi));
    check("mosi_tail", tail, 0);
    check("idx_order", bad_idx, 0);
    check("data_match", bad_data, 0);
    check("hold_between", bad_hold, 0);
    check("sclk_period", bad_period, 0);
    check("done_count", fdone, 1);
    if (v.poke) begin
      repeat (3) begin
        @(negedge clk);
        idle_low += int'(!s_cs_n) + int'(s_busy);
      end
      check("no_queued_start", idle_low, 0);
    end
  endtask

  task automatic reset_abort();
    int cyc = 0, seen = 0, dones = 0, low = 0;
    sel = 1'b0;
    @(negedge clk);
    cmd_word = 16'h6800;
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    while (seen < 60 && cyc < 2000) begin
      @(negedge clk);
      cyc++;
      if (s_valid) seen++;
    end
    check("reach_bit60", seen, 60);
    rst = 1'b1;
    #1;
    check("rst_async_ctl", int'({s_cs_n, s_sclk, s_busy, s_valid, s_mosi, s_done}), int'(6'b110000));
    check("rst_async_bits", int'(s_data) | int'(s_idx), 0);
    repeat (3) begin
      @(negedge clk);
      dones += int'(s_done);
    end
    rst = 1'b0;
    repeat (600) begin
      @(negedge clk);
      dones += int'(s_done);
      low += int'(!s_cs_n);
    end
    check("abort_no_done", dones, 0);
    check("abort_stays_idle", low, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached, got no summary expected one");
    $fatal(1);
  end

  initial begin
    logic [15:0] r;
    r = 16'($urandom);
    vecs[0] = '{16'h6800, 0, 16'b0110_1000_0000_0000, 1'b0, 1'b0, 4 + 2*2*128 + 4, 128};
    vecs[1] = '{r, 1, r, 1'b0, 1'b1, 4 + 2*2*128 + 4, 128};
    vecs[2] = '{16'hFFFF, 1, 16'hFFFF, 1'b0, 1'b0, 4 + 2*2*128 + 4, 128};
    vecs[3] = '{16'h0001, 0, 16'h0001, 1'b0, 1'b0, 4 + 2*2*128 + 4, 128};
    vecs[4] = '{16'hBEEF, 1, 16'hBEEF, 1'b1, 1'b0, 4 + 2*1*16 + 4, 16};
    vecs[5] = '{16'h6800, 0, 16'h6800, 1'b1, 1'b0, 4 + 2*1*16 + 4, 16};
    repeat (3) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      sel = d[0];
      #1;
      check("reset_ctl", int'({s_cs_n, s_sclk, s_mosi, s_valid, s_done, s_busy}), int'(6'b110000));
      check("reset_bits", int'(s_data) | int'(s_idx), 0);
    end
    @(negedge clk);
    rst = 1'b0;
    foreach (vecs[i]) do_frame(vecs[i], 1'b0);
    reset_abort();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    do_frame(vecs[0], 1'b1);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
